// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
// The transaction record is captured once when a request wins and is replayed on the memory side.
package mem_port_arbiter_pkg;

  localparam int XLEN = 32;
  localparam int BE_W = 4;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_LS = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  typedef struct packed {
    logic            owner;
    logic [XLEN-1:0] addr;
    logic            we;
    logic [XLEN-1:0] wdata;
    logic [BE_W-1:0] be;
  } txn_t;

  // Fetches are always reads with no byte lanes enabled; only load/store carries we/wdata/be.
  function automatic txn_t build_txn(
    input logic            owner,
    input logic [XLEN-1:0] if_addr,
    input logic [XLEN-1:0] ls_addr,
    input logic            ls_we,
    input logic [XLEN-1:0] ls_wdata,
    input logic [BE_W-1:0] ls_be
  );
    txn_t t;
    t       = '0;
    t.owner = owner;
    if (owner == OWNER_LS) begin
      t.addr  = ls_addr;
      t.we    = ls_we;
      t.wdata = ls_wdata;
      t.be    = ls_be;
    end else begin
      t.addr  = if_addr;
    end
    return t;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, load/store port and shared memory port.
// The arbiter takes the slave view; the surrounding core and memory see the master view.
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic            if_gnt;
  logic            if_rvalid;
  logic [XLEN-1:0] if_rdata;

  logic            ls_req;
  logic            ls_we;
  logic [XLEN-1:0] ls_addr;
  logic [XLEN-1:0] ls_wdata;
  logic [BE_W-1:0] ls_be;
  logic            ls_gnt;
  logic            ls_rvalid;
  logic [XLEN-1:0] ls_rdata;

  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [BE_W-1:0] mem_be;
  logic            mem_ready;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    input  ls_req, ls_we, ls_addr, ls_wdata, ls_be,
    input  mem_ready, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output if_req, if_addr,
    output ls_req, ls_we, ls_addr, ls_wdata, ls_be,
    output mem_ready, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

endinterface

// File: rtl/mem_port_arbiter_arb_rr2.sv
// Two-way round-robin pick: on a tie the requester that did not win last time goes first.
// Purely combinational; the caller owns the last-winner register.
module arb_rr2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner
);

  always_comb begin
    case (req)
      2'b11:   winner = ~last;
      2'b10:   winner = OWNER_LS;
      default: winner = OWNER_IF;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction at a time.
// IDLE captures the winning request, ISSUE holds it on the bus until accepted, WAIT routes the response.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus,
  output logic               sel,
  output logic               busy,
  output logic               err
);

  state_e state_q, state_d;
  txn_t   txn_q, txn_d;
  logic   last_owner_q, last_owner_d;
  logic   err_q, err_d;

  logic   winner;
  logic   any_req;
  logic   issue_ack;
  logic   wait_done;

  arb_rr2 u_arb (
    .req    ({bus.ls_req, bus.if_req}),
    .last   (last_owner_q),
    .winner (winner)
  );

  assign any_req = bus.if_req | bus.ls_req;

  // Handshakes are masked while rst is high so an abandoned transaction never pulses gnt or rvalid.
  assign issue_ack = (state_q == ST_ISSUE) & bus.mem_ready  & ~rst;
  assign wait_done = (state_q == ST_WAIT)  & bus.mem_rvalid & ~rst;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
    state_d      = state_q;
    txn_d        = txn_q;
    last_owner_d = last_owner_q;
    err_d        = err_q | (bus.mem_rvalid & (state_q != ST_WAIT));

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          txn_d        = build_txn(winner, bus.if_addr, bus.ls_addr,
                                   bus.ls_we, bus.ls_wdata, bus.ls_be);
          last_owner_d = winner;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus.mem_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.mem_rvalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      state_q      <= ST_IDLE;
      txn_q        <= '0;
      last_owner_q <= OWNER_LS;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      txn_q        <= txn_d;
      last_owner_q <= last_owner_d;
      err_q        <= err_d;
    end
  end

  assign bus.mem_req   = (state_q == ST_ISSUE) & ~rst;
  assign bus.mem_we    = txn_q.we;
  assign bus.mem_addr  = txn_q.addr;
  assign bus.mem_wdata = txn_q.wdata;
  assign bus.mem_be    = txn_q.be;

  assign bus.if_gnt    = issue_ack & (txn_q.owner == OWNER_IF);
  assign bus.ls_gnt    = issue_ack & (txn_q.owner == OWNER_LS);
  assign bus.if_rvalid = wait_done & (txn_q.owner == OWNER_IF);
  assign bus.ls_rvalid = wait_done & (txn_q.owner == OWNER_LS);

  // Read data is shared; the rvalid pulses alone qualify it.
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.ls_rdata  = bus.mem_rdata;

  assign sel  = txn_q.owner;
  assign busy = (state_q != ST_IDLE);
  assign err  = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel, busy, err;

  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  mem_port_arbiter dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .sel  (sel),
    .busy (busy),
    .err  (err)
  );

  int total = 0;
  int bad   = 0;

  // Reference: at most one transaction record in flight, plus fairness and error memory.
  typedef struct {
    bit          valid;
    bit          accepted;
    bit          owner;
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
    logic [3:0]  be;
  } ref_txn_t;

  ref_txn_t m_txn;
  bit       m_last;
  bit       m_sel;
  bit       m_err;

  bit          saw_if_gnt, saw_ls_gnt, mem_wait;
  bit          served[$];
  logic        s_mem_req, s_mem_we, s_if_gnt, s_ls_gnt, s_if_rvalid, s_ls_rvalid;
  logic        s_sel, s_busy, s_err;
  logic [31:0] s_mem_addr, s_mem_wdata, s_if_rdata, s_ls_rdata;
  logic [3:0]  s_mem_be;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare one cycle's outputs at the falling edge, then advance the model across the rising edge.
  task automatic step();
    bit exp_req, done, w;
    @(negedge clk);
    exp_req = m_txn.valid && !m_txn.accepted && !rst;
    done    = m_txn.valid && m_txn.accepted && bus.mem_rvalid && !rst;

    s_mem_req = bus.mem_req;   s_mem_we = bus.mem_we;     s_mem_be = bus.mem_be;
    s_mem_addr = bus.mem_addr; s_mem_wdata = bus.mem_wdata;
    s_if_gnt = bus.if_gnt;     s_ls_gnt = bus.ls_gnt;
    s_if_rvalid = bus.if_rvalid; s_ls_rvalid = bus.ls_rvalid;
    s_if_rdata = bus.if_rdata; s_ls_rdata = bus.ls_rdata;
    s_sel = sel; s_busy = busy; s_err = err;

    check("busy",      32'(busy),          32'(m_txn.valid));
    check("sel",       32'(sel),           32'(m_sel));
    check("err",       32'(err),           32'(m_err));
    check("mem_req",   32'(bus.mem_req),   32'(exp_req));
    check("if_gnt",    32'(bus.if_gnt),    32'(exp_req && bus.mem_ready && !m_txn.owner));
    check("ls_gnt",    32'(bus.ls_gnt),    32'(exp_req && bus.mem_ready &&  m_txn.owner));
    check("if_rvalid", 32'(bus.if_rvalid), 32'(done && !m_txn.owner));
    check("ls_rvalid", 32'(bus.ls_rvalid), 32'(done &&  m_txn.owner));
    if (exp_req) begin
      check("mem_addr", bus.mem_addr,     m_txn.addr);
      check("mem_we",   32'(bus.mem_we),  32'(m_txn.we));
      check("mem_be",   32'(bus.mem_be),  32'(m_txn.be));
      if (m_txn.we) check("mem_wdata", bus.mem_wdata, m_txn.wdata);
    end
    if (done && !m_txn.owner) check("if_rdata", bus.if_rdata, bus.mem_rdata);
    if (done &&  m_txn.owner) check("ls_rdata", bus.ls_rdata, bus.mem_rdata);

    if (bus.if_gnt) served.push_back(1'b0);
    if (bus.ls_gnt) served.push_back(1'b1);

    if (rst) begin
      m_txn.valid = 0; m_txn.accepted = 0; m_last = 1; m_sel = 0; m_err = 0;
      saw_if_gnt = 0; saw_ls_gnt = 0; mem_wait = 0;
    end else begin
      saw_if_gnt = bus.if_gnt;
      saw_ls_gnt = bus.ls_gnt;
      if (bus.if_gnt || bus.ls_gnt) mem_wait = 1;
      else if (bus.mem_rvalid)      mem_wait = 0;

      if (bus.mem_rvalid && !(m_txn.valid && m_txn.accepted)) m_err = 1;
      if (!m_txn.valid) begin
        if (bus.if_req || bus.ls_req) begin
          w = (bus.if_req && bus.ls_req) ? !m_last : bus.ls_req;
          m_txn.valid = 1; m_txn.accepted = 0; m_txn.owner = w;
          m_txn.addr  = w ? bus.ls_addr  : bus.if_addr;
          m_txn.we    = w ? bus.ls_we    : 1'b0;
          m_txn.wdata = w ? bus.ls_wdata : 32'h0;
          m_txn.be    = w ? bus.ls_be    : 4'h0;
          m_last = w; m_sel = w;
        end
      end else if (!m_txn.accepted) begin
        if (bus.mem_ready) m_txn.accepted = 1;
      end else if (bus.mem_rvalid) begin
        m_txn.valid = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    bus.if_req = 0; bus.ls_req = 0; bus.mem_ready = 0; bus.mem_rvalid = 0;
    step();
    step();
    rst = 0;
  endtask

  task automatic run(input int n, input int req_pct, input int ready_pct, input int rv_pct);
    for (int i = 0; i < n; i++) begin
      if (saw_if_gnt) bus.if_req = 0;
      if (saw_ls_gnt) bus.ls_req = 0;
      if (!bus.if_req && int'($urandom_range(99, 0)) < req_pct) begin
        bus.if_req  = 1;
        bus.if_addr = $urandom;
      end
      if (!bus.ls_req && int'($urandom_range(99, 0)) < req_pct) begin
        bus.ls_req   = 1;
        bus.ls_we    = 1'($urandom);
        bus.ls_addr  = $urandom;
        bus.ls_wdata = $urandom;
        bus.ls_be    = 4'($urandom);
      end
      bus.mem_ready  = int'($urandom_range(99, 0)) < ready_pct;
      bus.mem_rvalid = mem_wait && (int'($urandom_range(99, 0)) < rv_pct);
      bus.mem_rdata  = $urandom;
      step();
    end
  endtask

  initial begin
    m_txn = '{default: 0}; m_last = 1; m_sel = 0; m_err = 0;
    bus.if_req = 0; bus.if_addr = 0;
    bus.ls_req = 0; bus.ls_we = 0; bus.ls_addr = 0; bus.ls_wdata = 0; bus.ls_be = 0;
    bus.mem_ready = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;

    // Reset state
    do_reset();
    check("rst_busy",    32'(s_busy),    32'd0);
    check("rst_sel",     32'(s_sel),     32'd0);
    check("rst_err",     32'(s_err),     32'd0);
    check("rst_mem_req", 32'(s_mem_req), 32'd0);

    // Lone fetch with a two-cycle response delay
    bus.if_req = 1; bus.if_addr = 32'h0000_0100;
    step();
    bus.mem_ready = 1;
    step();
    check("043_mem_req", 32'(s_mem_req), 32'd1);
    check("043_sel",     32'(s_sel),     32'd0);
    check("043_addr",    s_mem_addr,     32'h0000_0100);
    check("043_if_gnt",  32'(s_if_gnt),  32'd1);
    bus.if_req = 0; bus.mem_ready = 0;
    step();
    check("043_no_rv",   32'(s_if_rvalid), 32'd0);
    bus.mem_rvalid = 1; bus.mem_rdata = 32'hDEAD_BEEF;
    step();
    check("043_if_rvalid", 32'(s_if_rvalid), 32'd1);
    check("043_if_rdata",  s_if_rdata,       32'hDEAD_BEEF);
    bus.mem_rvalid = 0;
    step();
    check("043_idle", 32'(s_busy), 32'd0);

    // Continuous contention alternates starting with fetch
    do_reset();
    served.delete();
    bus.if_req = 1; bus.if_addr = $urandom;
    bus.ls_req = 1; bus.ls_we = 0; bus.ls_addr = $urandom; bus.ls_be = 4'hF;
    run(12, 100, 100, 100);
    check("044_count", 32'(served.size()), 32'd4);
    for (int i = 0; i < served.size() && i < 4; i++)
      check("044_order", 32'(served[i]), 32'(i % 2));

    // Store stalled by memory for three cycles
    do_reset();
    bus.ls_req = 1; bus.ls_we = 1; bus.ls_addr = 32'h0000_2000;
    bus.ls_wdata = 32'h1234_5678; bus.ls_be = 4'b0011;
    step();
    for (int k = 0; k < 4; k++) begin
      bus.mem_ready = (k == 3);
      step();
      check("045_addr",  s_mem_addr,        32'h0000_2000);
      check("045_wdata", s_mem_wdata,       32'h1234_5678);
      check("045_be",    32'(s_mem_be),     32'h3);
      check("045_we",    32'(s_mem_we),     32'd1);
      check("045_gnt",   32'(s_ls_gnt),     32'(k == 3));
    end
    bus.ls_req = 0; bus.mem_ready = 0;
    step();
    bus.mem_rvalid = 1;
    step();
    check("045_ls_rvalid", 32'(s_ls_rvalid), 32'd1);
    bus.mem_rvalid = 0;
    step();

    // Stray response while idle sets the sticky error
    do_reset();
    bus.mem_rvalid = 1;
    step();
    check("046_if_rv", 32'(s_if_rvalid), 32'd0);
    check("046_ls_rv", 32'(s_ls_rvalid), 32'd0);
    bus.mem_rvalid = 0;
    repeat (3) step();
    check("046_err_sticky", 32'(s_err), 32'd1);
    do_reset();
    check("046_err_clr", 32'(s_err), 32'd0);

    // Reset while waiting abandons the transaction
    bus.if_req = 1; bus.if_addr = $urandom; bus.mem_ready = 1;
    step();
    step();
    bus.if_req = 0; bus.mem_ready = 0;
    step();
    rst = 1; bus.mem_rvalid = 1;
    step();
    check("047_rst_rv", 32'(s_if_rvalid), 32'd0);
    rst = 0; bus.mem_rvalid = 0;
    step();
    check("047_busy", 32'(s_busy), 32'd0);
    bus.mem_rvalid = 1;
    step();
    check("047_late_if_rv", 32'(s_if_rvalid), 32'd0);
    check("047_late_ls_rv", 32'(s_ls_rvalid), 32'd0);
    bus.mem_rvalid = 0;
    step();
    check("047_err", 32'(s_err), 32'd1);

    // Request withdrawn during ISSUE still completes
    do_reset();
    bus.ls_req = 1; bus.ls_we = 0; bus.ls_addr = $urandom; bus.ls_be = 4'hF;
    step();
    bus.ls_req = 0;
    step();
    bus.mem_ready = 1;
    step();
    check("048_ls_gnt", 32'(s_ls_gnt), 32'd1);
    bus.mem_ready = 0; bus.mem_rvalid = 1; bus.mem_rdata = $urandom;
    step();
    check("048_ls_rvalid", 32'(s_ls_rvalid), 32'd1);
    bus.mem_rvalid = 0;
    step();

    // Randomized traffic
    do_reset();
    run(2000, 40, 50, 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 if_req  input  1  instruction-fetch read request; held until if_gnt.
REQ-004 if_addr  input  32  fetch byte address.
REQ-005 if_gnt  output  1  one-cycle pulse: fetch request accepted by memory.
REQ-006 if_rvalid  output  1  one-cycle pulse: fetch data valid.
REQ-007 if_rdata  output  32  fetch read data.
REQ-008 ls_req  input  1  load/store request; held until ls_gnt.
REQ-009 ls_we  input  1  1 = store, 0 = load.
REQ-010 ls_addr  input  32  load/store byte address.
REQ-011 ls_wdata  input  32  store data.
REQ-012 ls_be  input  4  store byte enables.
REQ-013 ls_gnt  output  1  one-cycle pulse: load/store accepted.
REQ-014 ls_rvalid  output  1  one-cycle pulse: load data or store ack.
REQ-015 ls_rdata  output  32  load data.
REQ-016 mem_req, mem_we  output  1 each  memory request and write flag.
REQ-017 mem_addr, mem_wdata  output  32 each; mem_be  output  4.
REQ-018 mem_ready  input  1  memory accepts request this cycle.
REQ-019 mem_rvalid  input  1; mem_rdata  input  32  response and read data.
REQ-020 sel  output  1  current owner, 0 = fetch, 1 = load/store; drives the datapath address-select mux.
REQ-021 busy  output  1  high whenever the state is not IDLE.
REQ-022 err  output  1  sticky protocol-error flag.

Function
REQ-023 The FSM SHALL have three states: IDLE, ISSUE and WAIT.
REQ-024 In IDLE with any request, the block SHALL register the owner, address, we, wdata and be; set sel to the owner; and enter ISSUE on the next edge.
REQ-025 When both requesters are active, the block SHALL grant the one not equal to last_owner; a single requester SHALL always win.
REQ-026 last_owner SHALL update to the winner on every IDLE-to-ISSUE transition.
REQ-027 Fetch requests SHALL drive mem_we=0 and mem_be=4'b0000.
REQ-028 In ISSUE, mem_req SHALL be 1 and mem_addr, mem_we, mem_wdata and mem_be SHALL come from the registered values.
REQ-029 In ISSUE, mem_req&mem_ready SHALL pulse the owner's gnt in the same cycle and move the FSM to WAIT.
REQ-030 Latency: a request sampled in IDLE at cycle N SHALL produce mem_req at N+1.
REQ-031 In WAIT, mem_rvalid SHALL pulse the owner's rvalid in the same cycle, with rdata = mem_rdata; the FSM SHALL then return to IDLE.
REQ-032 One IDLE cycle SHALL separate consecutive transactions, and at most one transaction SHALL be outstanding.
REQ-033 Non-owner rvalid and gnt SHALL stay 0; if_rdata and ls_rdata MAY pass mem_rdata unconditionally.
REQ-034 Once in ISSUE, a transaction SHALL complete even if the owner's request drops.
REQ-035 mem_rvalid in IDLE or ISSUE SHALL be ignored for routing and SHALL set err; err SHALL clear only on rst.
REQ-036 mem_ready outside ISSUE SHALL be ignored.
REQ-037 mem_req SHALL be 0 in IDLE and WAIT.

Reset
REQ-038 rst SHALL force: state IDLE, last_owner=1 (fetch wins the first tie), sel=0, busy=0, err=0.
REQ-039 rst SHALL also force all gnt, rvalid and mem_req outputs to 0 and all registered address/data fields to 0.
REQ-040 rst mid-transaction SHALL abandon the transaction silently, with no gnt or rvalid to either requester.

Structure
REQ-041 A shared package SHALL hold the state enum, OWNER_IF=1'b0, OWNER_LS=1'b1 and the width constants XLEN=32 and BE_W=4.
REQ-042 Two-way round-robin selection SHALL live in the combinational sub-module arb_rr2 (inputs req[1:0] and last; output winner).

Verification
REQ-043 Scenario: lone if_req, if_addr=0x0000_0100; mem_ready at the first ISSUE cycle; mem_rvalid 2 cycles later with 0xDEAD_BEEF -> mem_req at N+1 with sel=0, if_gnt 1 cycle, if_rvalid 1 cycle with if_rdata=0xDEAD_BEEF.
REQ-044 Scenario: simultaneous if_req and ls_req after reset -> fetch served first, then load/store; repeating both continuously -> strict alternation IF, LS, IF, LS.
REQ-045 Scenario: store ls_addr=0x0000_2000, wdata=0x1234_5678, be=4'b0011; mem_ready held 0 for 3 cycles -> mem_* outputs stable for all 4 ISSUE cycles; ls_gnt only on the ready cycle.
REQ-046 Scenario: mem_rvalid pulsed while IDLE -> err=1 and stays 1; no rvalid to either port; next rst -> err=0.
REQ-047 Scenario: rst asserted in WAIT -> next cycle state IDLE with busy=0; a later mem_rvalid -> no rvalid to either port, and err is set.
REQ-048 Scenario: ls_req dropped during ISSUE -> transaction completes with ls_gnt and ls_rvalid.
